// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: fetch controller for a byte-wide instruction memory.
// It reads four bytes per word and assembles them big-endian. The finished
// word is handed to decode over a valid/ready handshake. Redirects reload
// the PC, and an unaligned redirect parks the block in a sticky error state.
module imem_fetch_sequencer #(
    parameter int          MEM_BYTES = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_en,
    output logic [31:0]      mem_addr,
    input  logic [7:0]       mem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic             busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] word_count
);

    // PC is held modulo MEM_BYTES, so narrow registers give the wrap for free
    localparam int             AW       = $clog2(MEM_BYTES);
    localparam logic [AW-1:0]  RST_PC   = RESET_PC[AW-1:0];
    localparam logic [AW-1:0]  PC_STEP  = AW'(32'd4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        instr_q, instr_d;
    logic [AW-1:0]      instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               misalign_err_q, misalign_err_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;

    logic               handshake_s;
    logic               redirect_ok_s;
    logic               redirect_bad_s;
    logic [AW-1:0]      addr_s;
    logic               unused_s;

    assign handshake_s    = (state_q == HOLD) && instr_valid_q && instr_ready;
    assign redirect_ok_s  = redirect_valid && (state_q != ERR) && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad_s = redirect_valid && (state_q != ERR) && (redirect_pc[1:0] != 2'b00);
    assign addr_s         = pc_q + {{(AW-2){1'b0}}, byte_cnt_q};
    assign unused_s       = ^redirect_pc[31:AW];

    // State and datapath registers; reset drops any partially assembled word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= RST_PC;
            byte_cnt_q     <= 2'd0;
            instr_q        <= 32'h0000_0000;
            instr_pc_q     <= '0;
            instr_valid_q  <= 1'b0;
            misalign_err_q <= 1'b0;
            word_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            byte_cnt_q     <= byte_cnt_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            instr_valid_q  <= instr_valid_d;
            misalign_err_q <= misalign_err_d;
            word_count_q   <= word_count_d;
        end
    end

    // Next-state logic; a redirect overrides every other transition outside ERR
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en) state_d = FETCH; else state_d = IDLE;
            FETCH:   if (byte_cnt_q == 2'd3) state_d = HOLD; else state_d = FETCH;
            HOLD: begin
                if (handshake_s) begin
                    if (fetch_en) state_d = FETCH; else state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
        if (redirect_bad_s) begin
            state_d = ERR;
        end else if (redirect_ok_s) begin
            if (fetch_en) state_d = FETCH; else state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Datapath updates: byte capture, handover, PC advance and redirect handling
    always_comb begin
        pc_d           = pc_q;
        byte_cnt_d     = byte_cnt_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        instr_valid_d  = instr_valid_q;
        misalign_err_d = misalign_err_q;
        word_count_d   = word_count_q;

        // the handshake counts even when a redirect lands in the same cycle
        if (handshake_s) begin
            word_count_d  = word_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            instr_valid_d = 1'b0;
            pc_d          = pc_q + PC_STEP;
        end else begin
            word_count_d  = word_count_q;
        end

        if (redirect_bad_s) begin
            // pc and byte_cnt stay put so mem_addr freezes in ERR
            misalign_err_d = 1'b1;
            instr_valid_d  = 1'b0;
            pc_d           = pc_q;
        end else if (redirect_ok_s) begin
            pc_d          = redirect_pc[AW-1:0];
            byte_cnt_d    = 2'd0;
            instr_valid_d = 1'b0;
        end else if (state_q == FETCH) begin
            case (byte_cnt_q)
                2'd0:    instr_d[31:24] = mem_rdata;
                2'd1:    instr_d[23:16] = mem_rdata;
                2'd2:    instr_d[15:8]  = mem_rdata;
                2'd3:    instr_d[7:0]   = mem_rdata;
                default: instr_d        = instr_q;
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                instr_valid_d = 1'b1;
                instr_pc_d    = pc_q;
            end else begin
                instr_valid_d = instr_valid_q;
            end
        end else begin
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Output decode straight from the registers
    always_comb begin
        mem_addr     = {{(32-AW){1'b0}}, addr_s};
        instr        = instr_q;
        instr_pc     = {{(32-AW){1'b0}}, instr_pc_q};
        instr_valid  = instr_valid_q;
        misalign_err = misalign_err_q;
        word_count   = word_count_q;
        case (state_q)
            FETCH:   busy = 1'b1;
            HOLD:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer with a byte memory model and a
// scoreboard of expected {instr_pc, instr} pairs popped on each handshake.
module tb_imem_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        busy;
    logic        misalign_err;
    logic [15:0] word_count;

    logic [7:0]  mem [0:255];
    logic [63:0] sb [$];
    int          checks_total;
    int          checks_failed;

    imem_fetch_sequencer #(
        .MEM_BYTES (256),
        .RESET_PC  (32'h0000_0000),
        .CNT_W     (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .busy           (busy),
        .misalign_err   (misalign_err),
        .word_count     (word_count)
    );

    assign mem_rdata = mem[mem_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = a;
        b1 = a + 8'd1;
        b2 = a + 8'd2;
        b3 = a + 8'd3;
        return {mem[b0], mem[b1], mem[b2], mem[b3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) else begin
            checks_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] a);
        sb.push_back({24'h0, a, word_at(a)});
    endtask

    // One clock: scoreboard check just before the edge, then settle after it
    task automatic cyc(input int n);
        logic [63:0] e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_instr", instr, e[31:0]);
                    chk("sb_pc", instr_pc, e[63:32]);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] w4;
        checks_total   = 0;
        checks_failed  = 0;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0]   = 8'h20; mem[1]   = 8'h08; mem[2]   = 8'h00; mem[3]   = 8'h05;
        mem[252] = 8'hAA; mem[253] = 8'hBB; mem[254] = 8'hCC; mem[255] = 8'hDD;

        #3;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wc", {16'd0, word_count}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);

        // first word from address 0
        @(posedge clk); #1;
        rst_n = 1'b1;
        fetch_en = 1'b1;
        push_exp(8'h00);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", mem_addr, 32'(i));
            chk("seq_nvalid", {31'd0, instr_valid}, 32'd0);
            cyc(1);
        end
        chk("w0_valid", {31'd0, instr_valid}, 32'd1);
        chk("w0_instr", instr, 32'h2008_0005);
        chk("w0_pc", instr_pc, 32'd0);
        chk("w0_busy", {31'd0, busy}, 32'd1);
        instr_ready = 1'b1;
        cyc(1);
        instr_ready = 1'b0;
        chk("w0_wc", {16'd0, word_count}, 32'd1);
        chk("w0_next_addr", mem_addr, 32'd4);
        chk("w0_drop", {31'd0, instr_valid}, 32'd0);

        // backpressure on the word at 4
        push_exp(8'h04);
        w4 = word_at(8'h04);
        cyc(4);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_instr", instr, w4);
            chk("bp_pc", instr_pc, 32'd4);
            chk("bp_addr", mem_addr, 32'd4);
            cyc(1);
        end
        instr_ready = 1'b1;
        cyc(1);
        instr_ready = 1'b0;
        chk("bp_wc", {16'd0, word_count}, 32'd2);
        chk("bp_addr8", mem_addr, 32'd8);

        // redirect mid-word at byte_cnt=2
        cyc(2);
        chk("rd_pre_addr", mem_addr, 32'd10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        cyc(1);
        redirect_valid = 1'b0;
        chk("rd_addr", mem_addr, 32'h40);
        chk("rd_nvalid", {31'd0, instr_valid}, 32'd0);
        push_exp(8'h40);
        cyc(4);
        chk("rd_valid", {31'd0, instr_valid}, 32'd1);
        chk("rd_pc", instr_pc, 32'h40);

        // handshake and redirect together, target at the top of memory
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFC;
        cyc(1);
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("hr_wc", {16'd0, word_count}, 32'd3);
        chk("hr_addr", mem_addr, 32'hFC);
        chk("hr_nvalid", {31'd0, instr_valid}, 32'd0);
        push_exp(8'hFC);
        cyc(4);
        chk("wr_instr", instr, 32'hAABB_CCDD);
        chk("wr_pc", instr_pc, 32'hFC);
        instr_ready = 1'b1;
        cyc(1);
        instr_ready = 1'b0;
        chk("wr_wc", {16'd0, word_count}, 32'd4);
        chk("wr_addr0", mem_addr, 32'd0);

        // fetch_en dropped during FETCH: word still completes
        push_exp(8'h00);
        fetch_en = 1'b0;
        cyc(4);
        chk("fe_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        cyc(1);
        instr_ready = 1'b0;
        chk("fe_wc", {16'd0, word_count}, 32'd5);
        chk("fe_busy", {31'd0, busy}, 32'd0);
        cyc(2);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_addr", mem_addr, 32'd4);

        // unaligned redirect -> sticky error, no fetching
        fetch_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        cyc(1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("err_flag", {31'd0, misalign_err}, 32'd1);
            chk("err_nvalid", {31'd0, instr_valid}, 32'd0);
            chk("err_addr", mem_addr, 32'd4);
            cyc(1);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        cyc(1);
        redirect_valid = 1'b0;
        chk("err_ign_addr", mem_addr, 32'd4);
        chk("err_ign_flag", {31'd0, misalign_err}, 32'd1);

        // reset pulse clears the error
        rst_n = 1'b0;
        #2;
        chk("rp_err", {31'd0, misalign_err}, 32'd0);
        chk("rp_addr", mem_addr, 32'd0);
        chk("rp_wc", {16'd0, word_count}, 32'd0);
        rst_n = 1'b1;

        // async reset in the middle of a fetch
        cyc(3);
        chk("ar_pre_addr", mem_addr, 32'd2);
        chk("ar_pre_busy", {31'd0, busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_addr", mem_addr, 32'd0);
        chk("ar_instr", instr, 32'd0);
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        chk("ar_ipc", instr_pc, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
        $finish;
    end

endmodule
